tanh_grad: RTL and testbench

- Backward-pass companion to the LSTM tanh activation unit.
- Given a stored tanh output y and an upstream gradient dy, computes dx = dy * (1 - y^2) in signed Q(DATA_WIDTH-FRACT_WIDTH).FRACT_WIDTH.
- Uses a single iterative shift-add multiplier, reused for both multiplies, under an FSM.
- Valid/ready handshake on input and output; sits between the gate-gradient buffer and the weight-update datapath.

---
 rtl/tanh_grad_if.sv | 22 ++
 rtl/tanh_grad.sv | 138 +++++++++++++
 tb/tb_tanh_grad.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/tanh_grad_if.sv
// Handshake bundle for tanh_grad: y/dy request side, dx response side.
interface tanh_grad_if #(
  parameter int DATA_WIDTH = 16
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] y;
  logic [DATA_WIDTH-1:0] dy;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] dx;

  modport master (
    output in_valid, y, dy, out_ready,
    input  in_ready, out_valid, dx
  );

  modport slave (
    input  in_valid, y, dy, out_ready,
    output in_ready, out_valid, dx
  );
endinterface

// File: rtl/tanh_grad.sv
// tanh backward pass: dx = dy * (1 - y^2), one shared shift-add multiplier.
// Define TANH_GRAD_ROUND_EN for round-half-up instead of truncation.
module tanh_grad #(
  parameter int DATA_WIDTH  = 16,
  parameter int FRACT_WIDTH = 12
) (
  input logic        clk,
  input logic        rst,
  tanh_grad_if.slave bus
);
  localparam int W  = DATA_WIDTH;
  localparam int AW = 2 * DATA_WIDTH;
  localparam int CW = $clog2(DATA_WIDTH + 1);
  localparam logic [W-1:0] ONE = W'(1) << FRACT_WIDTH;

  typedef enum logic [2:0] {
    IDLE, SQ, SUB, GRAD, DONE
  } state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [AW-1:0]  acc_q, acc_d;
  logic [AW-1:0]  mcand_q, mcand_d;
  logic [W-1:0]   mplier_q, mplier_d;
  logic           neg_q, neg_d;
  logic [W-1:0]   dya_q, dya_d;
  logic [W-1:0]   dx_q, dx_d;
  logic           ov_q, ov_d;

  logic [W-1:0]   y_abs, ya, dy_abs;
  logic [AW-1:0]  acc_step, acc_rnd, shr;
  logic [W-1:0]   sq, m;

  assign y_abs  = bus.y[W-1] ? -bus.y : bus.y;
  assign ya     = (y_abs > ONE) ? ONE : y_abs;
  assign dy_abs = bus.dy[W-1] ? -bus.dy : bus.dy;

  assign acc_step = mplier_q[0] ? acc_q + mcand_q : acc_q;

`ifdef TANH_GRAD_ROUND_EN
  localparam logic [AW-1:0] HALF = AW'(1) << (FRACT_WIDTH - 1);
  assign acc_rnd = acc_q + HALF;
`else
  assign acc_rnd = acc_q;
`endif

  // Clamps only bite when rounding pushes past the exact bound.
  assign shr = acc_rnd >> FRACT_WIDTH;
  assign sq  = (shr > AW'(ONE))   ? ONE   : shr[W-1:0];
  assign m   = (shr > AW'(dya_q)) ? dya_q : shr[W-1:0];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    neg_d    = neg_q;
    dya_d    = dya_q;
    dx_d     = dx_q;
    ov_d     = ov_q;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          acc_d    = '0;
          mcand_d  = AW'(ya);
          mplier_d = ya;
          neg_d    = bus.dy[W-1];
          dya_d    = dy_abs;
          cnt_d    = '0;
          state_d  = SQ;
        end
      end
      SQ: begin
        acc_d    = acc_step;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CW'(W - 1)) state_d = SUB;
      end
      SUB: begin
        acc_d    = '0;
        mcand_d  = AW'(dya_q);
        mplier_d = ONE - sq;
        cnt_d    = '0;
        state_d  = GRAD;
      end
      GRAD: begin
        // Extra cycle after the last bit lets dx come from a settled acc.
        if (cnt_q == CW'(W)) begin
          dx_d    = neg_q ? -m : m;
          ov_d    = 1'b1;
          state_d = DONE;
        end else begin
          acc_d    = acc_step;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          cnt_d    = cnt_q + 1'b1;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          ov_d    = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      neg_q    <= 1'b0;
      dya_q    <= '0;
      dx_q     <= '0;
      ov_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      neg_q    <= neg_d;
      dya_q    <= dya_d;
      dx_q     <= dx_d;
      ov_q     <= ov_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = ov_q;
  assign bus.dx        = dx_q;
endmodule

// File: tb/tb_tanh_grad.sv
// Directed and random checks of tanh_grad against an integer model.
// Model follows TANH_GRAD_ROUND_EN the same way as the design.
module tb_tanh_grad;
  localparam int W   = 16;
  localparam int F   = 12;
  localparam int LAT = 2 * W + 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  tanh_grad_if #(.DATA_WIDTH(W)) bus ();

  tanh_grad #(
    .DATA_WIDTH (W),
    .FRACT_WIDTH(F)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] ref_dx(
    input logic [W-1:0] ty, input logic [W-1:0] tdy
  );
    longint ay, ady, sq, d, m, r;
    bit neg;
    ay = longint'($signed(ty));
    if (ay < 0) ay = -ay;
    if (ay > (64'sd1 <<< F)) ay = 64'sd1 <<< F;
    ady = longint'($signed(tdy));
    neg = (ady < 0);
    if (neg) ady = -ady;
`ifdef TANH_GRAD_ROUND_EN
    sq = (ay * ay + (64'sd1 <<< (F - 1))) / (64'sd1 <<< F);
    if (sq > (64'sd1 <<< F)) sq = 64'sd1 <<< F;
    d = (64'sd1 <<< F) - sq;
    m = (d * ady + (64'sd1 <<< (F - 1))) / (64'sd1 <<< F);
    if (m > ady) m = ady;
`else
    sq = (ay * ay) / (64'sd1 <<< F);
    d = (64'sd1 <<< F) - sq;
    m = (d * ady) / (64'sd1 <<< F);
`endif
    r = neg ? -m : m;
    return r[W-1:0];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic txn(input logic [W-1:0] ty, input logic [W-1:0] tdy,
                     input int stall, input bit hold, input bit fixed,
                     input logic [W-1:0] fixed_dx);
    int lat;
    logic [W-1:0] exp;
    exp = fixed ? fixed_dx : ref_dx(ty, tdy);
    chk("in_ready_pre", 32'(bus.in_ready), 32'd1);
    bus.y = ty;
    bus.dy = tdy;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) bus.in_valid = 1'b0;
    bus.y = W'($urandom);
    bus.dy = W'($urandom);
    lat = 0;
    while (!bus.out_valid && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("latency", 32'(lat), 32'(LAT));
    chk("dx", 32'(bus.dx), 32'(exp));
    for (int i = 0; i < stall; i++) begin
      @(posedge clk);
      #1;
      chk("stall_valid", 32'(bus.out_valid), 32'd1);
      chk("stall_dx", 32'(bus.dx), 32'(exp));
      chk("stall_rdy", 32'(bus.in_ready), 32'd0);
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    chk("post_valid", 32'(bus.out_valid), 32'd0);
    chk("post_rdy", 32'(bus.in_ready), 32'd1);
    chk("post_dx", 32'(bus.dx), 32'(exp));
  endtask

  initial begin
    logic [W-1:0] ry, rdy;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.y = '0;
    bus.dy = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_rdy", 32'(bus.in_ready), 32'd1);
    chk("rst_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_dx", 32'(bus.dx), 32'd0);

    txn(16'd0, 16'd4096, 0, 1'b0, 1'b1, 16'd4096);
    txn(16'd2048, 16'd4096, 0, 1'b0, 1'b1, 16'd3072);
    txn(-16'sd2048, -16'sd8192, 0, 1'b0, 1'b1, -16'sd6144);
    txn(16'd5000, 16'd12345, 0, 1'b0, 1'b1, 16'd0);
    txn(16'd0, 16'h8000, 0, 1'b0, 1'b1, 16'h8000);
    txn(-16'sd4096, 16'd7777, 0, 1'b0, 1'b1, 16'd0);
    txn(16'd1000, 16'd4096, 0, 1'b0, 1'b1, 16'd3852);
`ifdef TANH_GRAD_ROUND_EN
    txn(16'd3000, 16'd4095, 0, 1'b0, 1'b1, 16'd1899);
`else
    txn(16'd3000, 16'd4095, 0, 1'b0, 1'b1, 16'd1898);
`endif
    txn(16'd1500, -16'sd3000, 10, 1'b1, 1'b0, 16'd0);

    bus.y = 16'd1234;
    bus.dy = 16'd5678;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (25) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("midrst_rdy", 32'(bus.in_ready), 32'd1);
    chk("midrst_valid", 32'(bus.out_valid), 32'd0);
    chk("midrst_dx", 32'(bus.dx), 32'd0);
    txn(16'd2048, 16'd4096, 0, 1'b0, 1'b1, 16'd3072);

    for (int i = 0; i < 24; i++) begin
      if (i % 3 == 0)
        ry = W'($urandom_range(8192) - 4096);
      else
        ry = W'($urandom);
      rdy = W'($urandom);
      txn(ry, rdy, int'($urandom_range(3)), 1'(i % 2), 1'b0, 16'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
